// File: rtl/vert_ucode_quicksort_pkg.sv
// Shared sizing, types and state encodings for the quicksort microcode bank loaders.
package vert_ucode_quicksort_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned W      = 32;
  localparam int unsigned BANK_N = 2;

  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned N_W    = $clog2(N + 1);
  localparam int unsigned BANK_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [N_W-1:0]    n_t;
  typedef logic [W-1:0]      w_t;
  typedef logic [BANK_W-1:0] bank_n_t;

  typedef enum logic [2:0] {
    BANK_IDLE    = 3'd0,
    BANK_LOADING = 3'd1,
    BANK_READY   = 3'd2,
    BANK_SORTING = 3'd3,
    BANK_DONE    = 3'd4
  } bank_status_t;

  // Bit 0 of the encoding doubles as the busy indication.
  typedef enum logic [2:0] {
    ENQUEUE_FSM_IDLE = 3'b000,
    ENQUEUE_FSM_LOAD = 3'b101
  } enqueue_fsm_t;

  localparam int unsigned ENQUEUE_FSM_BUSY_B = 0;

endpackage

// File: rtl/vert_ucode_quicksort_enqueue_if.sv
// Enqueue port bundle: input word stream, bank status, bank load/write side.
interface vert_ucode_quicksort_enqueue_if;
  import vert_ucode_quicksort_pkg::*;

  logic                      in_vld;
  w_t                        in_w;
  logic                      in_last;
  logic                      in_rdy;
  bank_status_t [BANK_N-1:0] bank_status;
  logic                      ld_start;
  logic                      ld_done;
  bank_n_t                   ld_bank;
  n_t                        ld_n;
  logic                      ld_error;
  logic                      wr_en;
  bank_n_t                   wr_bank;
  addr_t                     wr_addr;
  w_t                        wr_data;
  logic                      busy;

  modport master (
    output in_vld, in_w, in_last, bank_status,
    input  in_rdy, ld_start, ld_done, ld_bank, ld_n, ld_error,
    input  wr_en, wr_bank, wr_addr, wr_data, busy
  );

  modport slave (
    input  in_vld, in_w, in_last, bank_status,
    output in_rdy, ld_start, ld_done, ld_bank, ld_n, ld_error,
    output wr_en, wr_bank, wr_addr, wr_data, busy
  );

endinterface

// File: rtl/vert_ucode_quicksort_enqueue.sv
// Claims an idle bank round-robin and streams one packet of words into it,
// truncating at N words and flagging overflow on completion.
module vert_ucode_quicksort_enqueue
  import vert_ucode_quicksort_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  vert_ucode_quicksort_enqueue_if.slave bus
);

  enqueue_fsm_t state_q, state_d;
  bank_n_t      ptr_q, ptr_d;
  bank_n_t      bank_q, bank_d;
  n_t           count_q, count_d;
  logic         err_q, err_d;

  logic    wr_en_q, wr_en_d;
  bank_n_t wr_bank_q, wr_bank_d;
  addr_t   wr_addr_q, wr_addr_d;
  w_t      wr_data_q, wr_data_d;
  logic    ld_start_q, ld_start_d;
  logic    ld_done_q, ld_done_d;
  bank_n_t ld_bank_q, ld_bank_d;
  n_t      ld_n_q, ld_n_d;
  logic    ld_error_q, ld_error_d;

  logic    win_vld_c;
  bank_n_t win_bank_c;
  logic    accept_c;

  // First idle bank at or after the rotating pointer.
  always_comb begin
    win_vld_c  = 1'b0;
    win_bank_c = ptr_q;
    for (int unsigned i = 0; i < BANK_N; i++) begin
      if (!win_vld_c &&
          bus.bank_status[bank_n_t'((32'(ptr_q) + i) % BANK_N)] == BANK_IDLE) begin
        win_vld_c  = 1'b1;
        win_bank_c = bank_n_t'((32'(ptr_q) + i) % BANK_N);
      end
    end
  end

  assign accept_c = bus.in_vld && (state_q == ENQUEUE_FSM_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ENQUEUE_FSM_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENQUEUE_FSM_IDLE: if (win_vld_c) state_d = ENQUEUE_FSM_LOAD;
      ENQUEUE_FSM_LOAD: if (accept_c && bus.in_last) state_d = ENQUEUE_FSM_IDLE;
      default:          state_d = ENQUEUE_FSM_IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    bank_d     = bank_q;
    count_d    = count_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ld_start_d = 1'b0;
    ld_done_d  = 1'b0;
    ld_bank_d  = ld_bank_q;
    ld_n_d     = ld_n_q;
    ld_error_d = ld_error_q;
    case (state_q)
      ENQUEUE_FSM_IDLE: begin
        if (win_vld_c) begin
          bank_d     = win_bank_c;
          count_d    = '0;
          err_d      = 1'b0;
          ld_start_d = 1'b1;
          ld_bank_d  = win_bank_c;
        end
      end
      ENQUEUE_FSM_LOAD: begin
        if (accept_c) begin
          // Words beyond N are swallowed so the packet still drains to in_last.
          if (count_q < n_t'(N)) begin
            wr_en_d   = 1'b1;
            wr_bank_d = bank_q;
            wr_addr_d = addr_t'(count_q);
            wr_data_d = bus.in_w;
            count_d   = count_q + n_t'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus.in_last) begin
            ld_done_d  = 1'b1;
            ld_bank_d  = bank_q;
            ld_n_d     = count_d;
            ld_error_d = err_d;
            ptr_d      = bank_n_t'((32'(bank_q) + 1) % BANK_N);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      bank_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ld_start_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_bank_q  <= '0;
      ld_n_q     <= '0;
      ld_error_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      bank_q     <= bank_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ld_start_q <= ld_start_d;
      ld_done_q  <= ld_done_d;
      ld_bank_q  <= ld_bank_d;
      ld_n_q     <= ld_n_d;
      ld_error_q <= ld_error_d;
    end
  end

  assign bus.in_rdy   = (state_q == ENQUEUE_FSM_LOAD);
  assign bus.busy     = state_q[ENQUEUE_FSM_BUSY_B];
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_bank  = wr_bank_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.ld_start = ld_start_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_bank  = ld_bank_q;
  assign bus.ld_n     = ld_n_q;
  assign bus.ld_error = ld_error_q;

endmodule

// File: tb/tb_vert_ucode_quicksort_enqueue.sv
// Scoreboard bench: directed packets push expected bank events, a negedge monitor checks them.
module tb_vert_ucode_quicksort_enqueue;
  import vert_ucode_quicksort_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vert_ucode_quicksort_enqueue_if bus();

  vert_ucode_quicksort_enqueue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    bank_n_t bank;
    addr_t   addr;
    w_t      data;
  } wr_exp_t;

  typedef struct packed {
    bank_n_t bank;
    n_t      n;
    logic    err;
    logic    with_wr;
  } done_exp_t;

  bank_n_t   exp_start_q[$];
  wr_exp_t   exp_wr_q[$];
  done_exp_t exp_done_q[$];

  int checks = 0;
  int errors = 0;

  n_t      m_count;
  logic    m_err;
  bank_n_t m_bank;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_all(input bank_status_t s);
    for (int i = 0; i < int'(BANK_N); i++) bus.bank_status[i] = s;
  endtask

  task automatic begin_packet(input bank_n_t b);
    m_count = '0;
    m_err   = 1'b0;
    m_bank  = b;
    exp_start_q.push_back(b);
  endtask

  // Offers one word and records what the bank side should see for it.
  task automatic send(input w_t w, input logic last);
    int   cyc;
    logic wrf;
    cyc = 0;
    bus.in_vld  = 1'b1;
    bus.in_w    = w;
    bus.in_last = last;
    @(negedge clk);
    while (bus.in_rdy !== 1'b1) begin
      cyc++;
      if (cyc > 50) begin
        chk("in_rdy_timeout", 64'(bus.in_rdy), 64'(1));
        bus.in_vld = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (m_count < n_t'(16)) begin
      exp_wr_q.push_back('{m_bank, addr_t'(m_count), w});
      m_count = m_count + n_t'(1);
      wrf = 1'b1;
    end else begin
      m_err = 1'b1;
      wrf   = 1'b0;
    end
    if (last) exp_done_q.push_back('{m_bank, m_count, m_err, wrf});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_rdy"},   64'(bus.in_rdy),   64'(0));
    chk({tag, "_wr_en"},    64'(bus.wr_en),    64'(0));
    chk({tag, "_ld_start"}, 64'(bus.ld_start), 64'(0));
    chk({tag, "_ld_done"},  64'(bus.ld_done),  64'(0));
    chk({tag, "_ld_bank"},  64'(bus.ld_bank),  64'(0));
    chk({tag, "_ld_n"},     64'(bus.ld_n),     64'(0));
    chk({tag, "_ld_error"}, 64'(bus.ld_error), 64'(0));
    chk({tag, "_busy"},     64'(bus.busy),     64'(0));
  endtask

  // Monitor: every qualified output pops its expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ld_start === 1'b1) begin
        if (exp_start_q.size() == 0) chk("ld_start_unexpected", 64'(bus.ld_start), 64'(0));
        else begin
          bank_n_t e;
          e = exp_start_q.pop_front();
          chk("ld_start_bank", 64'(bus.ld_bank), 64'(e));
        end
      end
      if (bus.wr_en === 1'b1) begin
        if (exp_wr_q.size() == 0) chk("wr_en_unexpected", 64'(bus.wr_en), 64'(0));
        else begin
          wr_exp_t e;
          e = exp_wr_q.pop_front();
          chk("wr_bank_addr_data", 64'({bus.wr_bank, bus.wr_addr, bus.wr_data}), 64'(e));
        end
      end
      if (bus.ld_done === 1'b1) begin
        if (exp_done_q.size() == 0) chk("ld_done_unexpected", 64'(bus.ld_done), 64'(0));
        else begin
          done_exp_t e;
          e = exp_done_q.pop_front();
          chk("ld_done_bank_n_err_wr", 64'({bus.ld_bank, bus.ld_n, bus.ld_error, bus.wr_en}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_w    = '0;
    bus.in_last = 1'b0;
    set_all(BANK_READY);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both idle from reset: bank0 first, 4 words.
    begin_packet(bank_n_t'(0));
    set_all(BANK_IDLE);
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    send(32'd40, 1'b1);
    bus.in_vld = 1'b0;

    // Banks still idle: pointer moved on, so bank1 is claimed after a gap.
    begin_packet(bank_n_t'(1));
    @(negedge clk);
    chk("gap_in_rdy", 64'(bus.in_rdy), 64'(0));
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    bus.in_vld = 1'b0;
    set_all(BANK_READY);

    // Pointer back at 0 with bank0 busy loading: bank1 wins.
    bus.bank_status[0] = BANK_LOADING;
    bus.bank_status[1] = BANK_IDLE;
    begin_packet(bank_n_t'(1));
    send(32'd7, 1'b1);
    bus.in_vld = 1'b0;
    set_all(BANK_READY);

    // Overflow: 18 words into bank0.
    begin_packet(bank_n_t'(0));
    set_all(BANK_IDLE);
    for (int i = 1; i <= 18; i++) send(w_t'(100 + i), (i == 18));
    bus.in_vld = 1'b0;
    set_all(BANK_READY);

    // No idle bank: stall until bank0 is released.
    repeat (6) begin
      @(negedge clk);
      chk("stall_in_rdy", 64'(bus.in_rdy), 64'(0));
    end
    chk("stall_busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    begin_packet(bank_n_t'(0));
    bus.bank_status[0] = BANK_IDLE;
    @(negedge clk);
    chk("release_in_rdy", 64'(bus.in_rdy), 64'(0));
    send(32'd99, 1'b1);
    bus.in_vld = 1'b0;
    set_all(BANK_READY);

    // Reset after 5 of 8 words into bank1.
    begin_packet(bank_n_t'(1));
    set_all(BANK_IDLE);
    for (int i = 0; i < 5; i++) send(w_t'(200 + i), 1'b0);
    chk("mid_load_busy", 64'(bus.busy), 64'(1));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_vld = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    begin_packet(bank_n_t'(0));
    rst_n = 1'b1;
    send(32'd300, 1'b0);
    send(32'd301, 1'b1);
    bus.in_vld = 1'b0;
    set_all(BANK_READY);

    repeat (5) @(negedge clk);
    chk("start_q_drained", 64'(exp_start_q.size()), 64'(0));
    chk("wr_q_drained",    64'(exp_wr_q.size()),    64'(0));
    chk("done_q_drained",  64'(exp_done_q.size()),  64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
